data_sram_responder: RTL and testbench

DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

---
 rtl/data_sram_responder.sv | 136 +++++++++++++
 tb/tb_data_sram_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Pipelined data-port responder in front of a synchronous single-port RAM, LAT-cycle fixed response latency.
// Optional macro DRSP_STALL_EN adds LFSR-driven pseudo-random back-pressure on data_addr_ok.
module data_sram_responder #(
    parameter int ADDR_W  = 12,
    parameter int LAT     = 2,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    input  logic [3:0]        data_wstrb,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] outstanding_r;
    logic [LAT-1:0]   valid_r;
    logic [LAT-1:0]   is_read_r;
    logic [31:0]      last_data_s;
    logic             gate_s;
    logic             accept_s;
    logic             unused_s;

    assign unused_s = ^{data_size, data_addr[31:ADDR_W+2], data_addr[1:0]};

`ifdef DRSP_STALL_EN
    logic [7:0] lfsr_r;

    // Free-running back-pressure LFSR, taps 8,6,5,4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
        end
    end

    assign gate_s = lfsr_r[0];
`else
    assign gate_s = 1'b1;
`endif

    // A slot released by this cycle's data_ok may be refilled in the same cycle,
    // which is what lets MAX_OUT >= LAT sustain one acceptance per cycle.
    assign data_data_ok = valid_r[LAT-1];
    assign data_addr_ok = !rst && gate_s && ((outstanding_r < MAX_CNT) || data_data_ok);
    assign accept_s     = data_req && data_addr_ok;

    // RAM access is launched combinationally in the acceptance cycle.
    always_comb begin
        ram_addr  = data_addr[ADDR_W+1:2];
        ram_wdata = data_wdata;
        if (accept_s) begin
            ram_en = 1'b1;
            ram_we = data_wr ? data_wstrb : 4'b0000;
        end else begin
            ram_en = 1'b0;
            ram_we = 4'b0000;
        end
    end

    // Response control pipeline: valid and read flag shift one stage per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r   <= {LAT{1'b0}};
            is_read_r <= {LAT{1'b0}};
        end else begin
            valid_r[0]   <= accept_s;
            is_read_r[0] <= !data_wr;
            for (int i = 1; i < LAT; i++) begin
                valid_r[i]   <= valid_r[i-1];
                is_read_r[i] <= is_read_r[i-1];
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            assign last_data_s = ram_rdata;
        end else begin : g_latn
            logic [31:0] data_r [1:LAT-1];

            // Data pipeline: stage 1 samples the RAM output, later stages shift.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 1; i < LAT; i++) begin
                        data_r[i] <= 32'h0000_0000;
                    end
                end else begin
                    data_r[1] <= ram_rdata;
                    for (int i = 2; i < LAT; i++) begin
                        data_r[i] <= data_r[i-1];
                    end
                end
            end

            assign last_data_s = data_r[LAT-1];
        end
    endgenerate

    // Outstanding request count; simultaneous accept and response cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, data_data_ok})
                2'b10:   outstanding_r <= outstanding_r + 4'd1;
                2'b01:   outstanding_r <= outstanding_r - 4'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Read data is forced to zero except on read responses.
    always_comb begin
        if (valid_r[LAT-1] && is_read_r[LAT-1]) begin
            data_rdata = last_data_s;
        end else begin
            data_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: directed steps plus random traffic against a
// queue-based response model and a flat memory model.
module tb_data_sram_responder;

    localparam int AW      = 12;
    localparam int LAT     = 4;
    localparam int MAX_OUT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data_req = 1'b0;
    logic          data_wr = 1'b0;
    logic [1:0]    data_size = 2'b10;
    logic [31:0]   data_addr = 32'h0;
    logic [31:0]   data_wdata = 32'h0;
    logic [3:0]    data_wstrb = 4'h0;
    logic [31:0]   data_rdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    data_sram_responder #(.ADDR_W(AW), .LAT(LAT), .MAX_OUT(MAX_OUT)) u_dut (
        .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] ram_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            if (ram_we == 4'b0000) ram_rdata <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        int          due;
        bit          rd;
        logic [31:0] data;
    } resp_t;

    resp_t       q[$];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    logic [7:0]  lfsr_m = 8'hA5;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        acc;
    logic        obs_aok;
    int          last_acc_cyc = 0;
    int          last_dok_cyc = 0;
    logic [31:0] last_rd = 32'h0;
    int          acc_cnt = 0;
    int          dok_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare at mid-cycle, update the model, advance past the edge.
    task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws);
        bit          resp;
        int          n_after;
        logic        exp_aok;
        logic [31:0] exp_rd;
        logic [AW-1:0] idx;
        resp_t       e;
        data_req   = req;
        data_wr    = wr;
        data_addr  = addr;
        data_wdata = wd;
        data_wstrb = ws;
        data_size  = 2'($urandom_range(0, 3));
        #4;
        idx     = addr[AW+1:2];
        obs_aok = data_addr_ok;
        if (data_data_ok) begin
            dok_cnt++;
            last_dok_cyc = cyc;
            last_rd      = data_rdata;
        end
        if (req && data_addr_ok) acc_cnt++;
        if (rst) begin
            q.delete();
            acc = 1'b0;
            chk("rst_data_ok", data_data_ok, 1'b0);
            chk("rst_rdata", data_rdata, 32'h0);
            chk("rst_ram_en", ram_en, 1'b0);
            chk("rst_ram_we", ram_we, 4'h0);
        end else begin
            resp    = (q.size() > 0) && (q[0].due == cyc);
            n_after = q.size() - (resp ? 1 : 0);
            exp_aok = (n_after < MAX_OUT);
`ifdef DRSP_STALL_EN
            exp_aok = exp_aok && lfsr_m[0];
`endif
            exp_rd = 32'h0;
            if (resp && q[0].rd) exp_rd = q[0].data;
            acc = req && exp_aok;
            chk("addr_ok", data_addr_ok, exp_aok);
            chk("data_ok", data_data_ok, resp);
            chk("rdata", data_rdata, exp_rd);
            chk("ram_en", ram_en, acc);
            chk("ram_we", ram_we, (acc && wr) ? ws : 4'h0);
            if (acc) begin
                chk("ram_addr", ram_addr, idx);
                if (wr) chk("ram_wdata", ram_wdata, wd);
            end
            if (resp) void'(q.pop_front());
            if (acc) begin
                last_acc_cyc = cyc;
                e.due  = cyc + LAT;
                e.rd   = !wr;
                e.data = wr ? 32'h0 : ref_mem[idx];
                q.push_back(e);
                if (wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (ws[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) lfsr_m = 8'hA5;
        else     lfsr_m = {lfsr_m[6:0], ^(lfsr_m & 8'hB8)};
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws);
        int n = 0;
        do begin
            step(1'b1, wr, addr, wd, ws);
            n++;
        end while (!acc && n < 64);
        chk("issue_accepted", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          start;
        logic [11:0] pat;
        logic [11:0] exp_pat;

        // Reset with a request held high: nothing may reach the RAM or the response port.
        rst = 1'b1;
        repeat (3) step(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        rst = 1'b0;

        // Full write then read of word 0x10; acceptance in the very first cycle out of reset.
        start = cyc;
        issue(1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF);
        chk("first_accept_cycle", last_acc_cyc, start);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        start = last_acc_cyc;
        idle(LAT + 1);
        chk("read_latency", last_dok_cyc - start, LAT);
        chk("full_write_read", last_rd, 32'h1122_3344);

        // Partial-strobe merge, then an all-zero strobe write that must change nothing.
        issue(1'b1, 32'h0000_0010, 32'hAABB_CCDD, 4'b0101);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        idle(LAT + 1);
        chk("strobe_merge", last_rd, 32'h11BB_33DD);
        issue(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        idle(LAT + 1);
        chk("zero_strobe", last_rd, 32'h11BB_33DD);

`ifndef DRSP_STALL_EN
        // Saturation with LAT=4, MAX_OUT=2: addr_ok runs two high, two low.
        acc_cnt = 0;
        dok_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
            pat[i]     = obs_aok;
            exp_pat[i] = ((i % 4) < 2);
        end
        idle(LAT + 1);
        chk("saturation_pattern", pat, exp_pat);
        chk("saturation_counts", dok_cnt, acc_cnt);
`endif

        // Preload words 0..15 (with junk in the ignored address bits), then random traffic.
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, ($urandom & 32'hFFFF_C003) | (32'(i) << 2), $urandom, 4'hF);
        end
        idle(LAT + 1);
        acc_cnt = 0;
        dok_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                 ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2),
                 $urandom, 4'($urandom_range(0, 15)));
        end
        idle(LAT + 2);
        chk("random_counts", dok_cnt, acc_cnt);

        // Reset with requests in flight: responses vanish, RAM keeps its contents.
        issue(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
        issue(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        rst = 1'b1;
        dok_cnt = 0;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b0;
        idle(LAT + 3);
        chk("no_data_ok_after_reset", dok_cnt, 0);
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        idle(LAT + 1);
        chk("ram_kept_over_reset", last_rd, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
